// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: game events, timer feedback and timer/display controls of the sequencer
interface timer_sequencer_if;
    logic [1:0] level;
    logic       game_start;
    logic       first_click;
    logic       pause_req;
    logic       game_won;
    logic       game_lost;
    logic [7:0] timer_seconds;
    logic       timer_elapsed;
    logic       tmr_rst;
    logic       tmr_start;
    logic       tmr_stop;
    logic [7:0] sec_to_count;
    logic       time_over;
    logic       warn;
    logic [7:0] used_sec;
    logic       running;
    modport slave (
        input  level, game_start, first_click, pause_req, game_won, game_lost,
               timer_seconds, timer_elapsed,
        output tmr_rst, tmr_start, tmr_stop, sec_to_count, time_over, warn, used_sec, running
    );
    modport master (
        output level, game_start, first_click, pause_req, game_won, game_lost,
               timer_seconds, timer_elapsed,
        input  tmr_rst, tmr_start, tmr_stop, sec_to_count, time_over, warn, used_sec, running
    );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: per-game sequencing of the countdown timer, timeout detection and elapsed-time reporting
module timer_sequencer #(
    parameter logic [7:0] SEC_EASY   = 8'd180,
    parameter logic [7:0] SEC_MEDIUM = 8'd120,
    parameter logic [7:0] SEC_HARD   = 8'd60,
    parameter logic [7:0] WARN_SEC   = 8'd10,
    parameter int         ARM_CYCLES = 3
) (
    input logic              clk,
    input logic              rst,
    timer_sequencer_if.slave bus
);
    localparam int CW = (ARM_CYCLES > 2) ? $clog2(ARM_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, ARM, READY, RUN, PAUSED, FINISHED, TIMEOUT} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sec_q, sec_d;
    logic [7:0]      used_q, used_d;
    logic            post_q;
    logic            tmr_rst_q, tmr_rst_d;
    logic            tmr_start_q, tmr_start_d;
    logic            tmr_stop_q, tmr_stop_d;
    logic            time_over_q, time_over_d;
    logic            warn_q, warn_d;
    logic            running_q, running_d;
    logic            ended;
    logic [7:0]      budget, consumed;
    assign ended    = bus.game_won | bus.game_lost;
    assign budget   = (bus.level == 2'b00) ? SEC_EASY : (bus.level == 2'b01) ? SEC_MEDIUM : SEC_HARD;
    assign consumed = (bus.timer_seconds > sec_q) ? 8'd0 : sec_q - bus.timer_seconds;
    // next state, latched budget/used time and the registered control outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sec_d     = sec_q;
        used_d    = used_q;
        tmr_rst_d = post_q;
        if (bus.game_start) begin
            state_d   = ARM;
            cnt_d     = CW'(ARM_CYCLES - 1);
            sec_d     = budget;
            used_d    = 8'd0;
            tmr_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                ARM: begin
                    state_d = (cnt_q == '0) ? READY : ARM;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                end
                READY: begin
                    state_d = ended ? FINISHED : bus.first_click ? RUN : READY;
                    used_d  = ended ? 8'd0 : used_q;
                end
                RUN: begin
                    state_d = ended ? FINISHED : bus.timer_elapsed ? TIMEOUT : bus.pause_req ? PAUSED : RUN;
                    used_d  = ended ? consumed : bus.timer_elapsed ? sec_q : used_q;
                end
                PAUSED: begin
                    state_d = ended ? FINISHED : bus.pause_req ? PAUSED : RUN;
                    used_d  = ended ? consumed : used_q;
                end
                FINISHED: state_d = FINISHED;
                TIMEOUT:  state_d = TIMEOUT;
                default:  state_d = IDLE;
            endcase
        end
        tmr_start_d = (state_d == RUN) || (state_d == PAUSED);
        tmr_stop_d  = (state_d == PAUSED) || (state_d == FINISHED);
        time_over_d = (state_d == TIMEOUT);
        running_d   = (state_d == RUN);
        warn_d      = tmr_start_d && (bus.timer_seconds != 8'd0) && (bus.timer_seconds <= WARN_SEC);
    end
    // state and output registers; tmr_rst stays high through reset and one cycle beyond
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sec_q       <= SEC_EASY;
            used_q      <= 8'd0;
            post_q      <= 1'b1;
            tmr_rst_q   <= 1'b1;
            tmr_start_q <= 1'b0;
            tmr_stop_q  <= 1'b0;
            time_over_q <= 1'b0;
            warn_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            used_q      <= used_d;
            post_q      <= 1'b0;
            tmr_rst_q   <= tmr_rst_d;
            tmr_start_q <= tmr_start_d;
            tmr_stop_q  <= tmr_stop_d;
            time_over_q <= time_over_d;
            warn_q      <= warn_d;
            running_q   <= running_d;
        end
    end
    assign bus.tmr_rst      = tmr_rst_q;
    assign bus.tmr_start    = tmr_start_q;
    assign bus.tmr_stop     = tmr_stop_q;
    assign bus.sec_to_count = sec_q;
    assign bus.time_over    = time_over_q;
    assign bus.warn         = warn_q;
    assign bus.used_sec     = used_q;
    assign bus.running      = running_q;
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed game scenarios checked against an expected-output scoreboard
module tb_timer_sequencer;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    typedef struct {
        string      tag;
        logic       r, st, sp;
        logic [7:0] sec;
        logic       to, w;
        logic [7:0] used;
        logic       run;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    timer_sequencer_if bus();
    timer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic r, input logic st, input logic sp,
                        input logic [7:0] sec, input logic to, input logic w,
                        input logic [7:0] used, input logic run);
        exp_t e;
        e = '{tag, r, st, sp, sec, to, w, used, run};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".tmr_rst"},   {7'd0, bus.tmr_rst},   {7'd0, e.r});
        chk({e.tag, ".tmr_start"}, {7'd0, bus.tmr_start}, {7'd0, e.st});
        chk({e.tag, ".tmr_stop"},  {7'd0, bus.tmr_stop},  {7'd0, e.sp});
        chk({e.tag, ".sec"},       bus.sec_to_count,      e.sec);
        chk({e.tag, ".time_over"}, {7'd0, bus.time_over}, {7'd0, e.to});
        chk({e.tag, ".warn"},      {7'd0, bus.warn},      {7'd0, e.w});
        chk({e.tag, ".used_sec"},  bus.used_sec,          e.used);
        chk({e.tag, ".running"},   {7'd0, bus.running},   {7'd0, e.run});
    endtask
    initial begin
        rst = 1'b1;
        bus.level = 2'b00;
        bus.game_start = 1'b0;
        bus.first_click = 1'b0;
        bus.pause_req = 1'b0;
        bus.game_won = 1'b0;
        bus.game_lost = 1'b0;
        bus.timer_seconds = 8'd0;
        bus.timer_elapsed = 1'b0;
        step("rst1", H, L, L, 8'd180, L, L, 8'd0, L);
        step("rst2", H, L, L, 8'd180, L, L, 8'd0, L);
        rst = 1'b0;
        step("post_rst", H, L, L, 8'd180, L, L, 8'd0, L);
        step("idle", L, L, L, 8'd180, L, L, 8'd0, L);
        bus.level = 2'b01;
        bus.game_start = 1'b1;
        step("arm_entry", H, L, L, 8'd120, L, L, 8'd0, L);
        bus.game_start = 1'b0;
        bus.level = 2'b10;
        step("arm2", L, L, L, 8'd120, L, L, 8'd0, L);
        step("arm3", L, L, L, 8'd120, L, L, 8'd0, L);
        step("ready", L, L, L, 8'd120, L, L, 8'd0, L);
        bus.first_click = 1'b1;
        step("run", L, H, L, 8'd120, L, L, 8'd0, H);
        bus.first_click = 1'b0;
        bus.timer_seconds = 8'd10;
        step("warn10", L, H, L, 8'd120, L, H, 8'd0, H);
        bus.pause_req = 1'b1;
        step("paused", L, H, H, 8'd120, L, H, 8'd0, L);
        bus.pause_req = 1'b0;
        step("resume", L, H, L, 8'd120, L, H, 8'd0, H);
        bus.timer_seconds = 8'd11;
        step("warn11", L, H, L, 8'd120, L, L, 8'd0, H);
        bus.timer_seconds = 8'd0;
        step("warn0", L, H, L, 8'd120, L, L, 8'd0, H);
        bus.timer_seconds = 8'd25;
        bus.game_won = 1'b1;
        bus.timer_elapsed = 1'b1;
        step("won_vs_elapsed", L, L, H, 8'd120, L, L, 8'd95, L);
        bus.game_won = 1'b0;
        bus.timer_elapsed = 1'b0;
        step("finished_hold", L, L, H, 8'd120, L, L, 8'd95, L);
        bus.game_start = 1'b1;
        bus.first_click = 1'b1;
        step("restart", H, L, L, 8'd60, L, L, 8'd0, L);
        bus.game_start = 1'b0;
        step("click_in_arm2", L, L, L, 8'd60, L, L, 8'd0, L);
        step("click_in_arm3", L, L, L, 8'd60, L, L, 8'd0, L);
        step("click_to_ready", L, L, L, 8'd60, L, L, 8'd0, L);
        step("click_run", L, H, L, 8'd60, L, L, 8'd0, H);
        bus.first_click = 1'b0;
        bus.timer_elapsed = 1'b1;
        step("timeout", L, L, L, 8'd60, H, L, 8'd60, L);
        bus.timer_elapsed = 1'b0;
        bus.game_won = 1'b1;
        step("timeout_hold", L, L, L, 8'd60, H, L, 8'd60, L);
        bus.game_won = 1'b0;
        bus.level = 2'b00;
        bus.game_start = 1'b1;
        step("easy_arm", H, L, L, 8'd180, L, L, 8'd0, L);
        bus.game_start = 1'b0;
        step("easy_arm2", L, L, L, 8'd180, L, L, 8'd0, L);
        step("easy_arm3", L, L, L, 8'd180, L, L, 8'd0, L);
        step("easy_ready", L, L, L, 8'd180, L, L, 8'd0, L);
        bus.first_click = 1'b1;
        step("easy_run", L, H, L, 8'd180, L, L, 8'd0, H);
        bus.first_click = 1'b0;
        bus.timer_seconds = 8'd200;
        bus.game_lost = 1'b1;
        step("saturate", L, L, H, 8'd180, L, L, 8'd0, L);
        bus.game_lost = 1'b0;
        bus.level = 2'b11;
        bus.game_start = 1'b1;
        step("hard_arm", H, L, L, 8'd60, L, L, 8'd0, L);
        bus.game_start = 1'b0;
        step("hard_arm2", L, L, L, 8'd60, L, L, 8'd0, L);
        step("hard_arm3", L, L, L, 8'd60, L, L, 8'd0, L);
        step("hard_ready", L, L, L, 8'd60, L, L, 8'd0, L);
        bus.timer_seconds = 8'd5;
        bus.game_lost = 1'b1;
        step("ready_lost", L, L, H, 8'd60, L, L, 8'd0, L);
        bus.game_lost = 1'b0;
        rst = 1'b1;
        step("mid_rst", H, L, L, 8'd180, L, L, 8'd0, L);
        rst = 1'b0;
        step("mid_post_rst", H, L, L, 8'd180, L, L, 8'd0, L);
        step("mid_idle", L, L, L, 8'd180, L, L, 8'd0, L);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
